// File: rtl/pwm_capture.sv
// PWM input capture: synchronises pwm_in, timestamps active/inactive edges against the
// timebase tick and publishes {period, high time} per cycle over a valid/ready port.
module pwm_capture #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     timebase,
    input  logic                     polarity,
    input  logic                     pwm_in,
    output logic [COUNTER_WIDTH-1:0] period_out,
    output logic [COUNTER_WIDTH-1:0] high_time_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     missed_sample,
    output logic                     overflow
);

    localparam int unsigned CW = COUNTER_WIDTH;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pol_q, pol_d;
    logic                   prev_q, prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          high_q, high_d;
    logic [CW-1:0]          per_out_q, per_out_d;
    logic [CW-1:0]          hi_out_q, hi_out_d;
    logic                   valid_q, valid_d;
    logic                   missed_q, missed_d;
    logic                   ovf_q, ovf_d;

    logic          lvl, rise, fall, sat, new_res;
    logic [CW-1:0] cnt_inc, res_per;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            pol_q     <= 1'b0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            high_q    <= '0;
            per_out_q <= '0;
            hi_out_q  <= '0;
            valid_q   <= 1'b0;
            missed_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            pol_q     <= pol_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            per_out_q <= per_out_d;
            hi_out_q  <= hi_out_d;
            valid_q   <= valid_d;
            missed_q  <= missed_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pol_d     = pol_q;
        cnt_d     = cnt_q;
        high_d    = high_q;
        ovf_d     = ovf_q;
        new_res   = 1'b0;
        res_per   = '0;
        per_out_d = per_out_q;
        hi_out_d  = hi_out_q;
        valid_d   = valid_q;
        missed_d  = 1'b0;

        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        // In IDLE the edge register follows the polarity about to be latched, so arming never sees a false edge.
        lvl    = sync_q[SYNC_STAGES-1] ^ ((state_q == IDLE) ? polarity : pol_q);
        prev_d = lvl;
        rise   = lvl & ~prev_q;
        fall   = ~lvl & prev_q;

        sat     = (cnt_q == CNT_MAX) && timebase;
        cnt_inc = (timebase && (cnt_q != CNT_MAX)) ? cnt_q + CW'(1) : cnt_q;

        // Published values are the tick count before this cycle's update: ticks in [edge_k, edge_k+1).
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ARM;
                    pol_d   = polarity;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CW'(timebase);
                end
            end
            HIGH: begin
                if (sat) begin
                    ovf_d   = 1'b1;
                    state_d = ARM;
                end else begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        high_d  = cnt_q;
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (sat) begin
                    ovf_d   = 1'b1;
                    state_d = ARM;
                end else if (rise) begin
                    new_res = 1'b1;
                    res_per = cnt_q;
                    state_d = HIGH;
                    cnt_d   = CW'(timebase);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            new_res = 1'b0;
        end

        // Result hand-off: load when the slot is free or being drained, otherwise drop and flag.
        if (new_res) begin
            if (!valid_q || data_ready) begin
                per_out_d = res_per;
                hi_out_d  = high_q;
                valid_d   = 1'b1;
            end else begin
                missed_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    assign period_out    = per_out_q;
    assign high_time_out = hi_out_q;
    assign data_valid    = valid_q;
    assign missed_sample = missed_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveforms are built as arrays, expected results are
// derived from edge positions and tick sums, then the arrays are played into the DUT.
module tb_pwm_capture;

    localparam int unsigned CW   = 8;
    localparam int          LAT  = 2;
    localparam int          AMAX = 2048;

    logic          clock = 1'b0;
    logic          reset, enable, timebase, polarity, pwm_in, data_ready;
    logic [CW-1:0] period_out, high_time_out;
    logic          data_valid, missed_sample, overflow;

    int checks = 0;
    int errors = 0;
    int miss_cnt = 0;
    int pres_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    typedef struct {
        int per;
        int hi;
    } res_t;
    res_t exp_q[$];

    logic act_arr [AMAX];
    logic tb_arr  [AMAX];
    logic rdy_arr [AMAX];
    int   n_arr;

    pwm_capture #(.COUNTER_WIDTH(CW), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .timebase(timebase),
        .polarity(polarity), .pwm_in(pwm_in), .period_out(period_out),
        .high_time_out(high_time_out), .data_valid(data_valid), .data_ready(data_ready),
        .missed_sample(missed_sample), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive this cycle's inputs.
    task automatic cyc(input logic a, input logic tb, input logic rdy);
        res_t r;
        @(negedge clock);
        if (data_valid === 1'b1 && (!prev_valid || prev_ready)) begin
            pres_cnt++;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("period", 32'(period_out), 32'(r.per));
                chk("high_time", 32'(high_time_out), 32'(r.hi));
            end
        end
        if (missed_sample === 1'b1) miss_cnt++;
        prev_valid = (data_valid === 1'b1);
        prev_ready = rdy;
        pwm_in     = a ^ polarity;
        timebase   = tb;
        data_ready = rdy;
    endtask

    task automatic push(input logic a, input int cnt, input int tbm, input logic rdy);
        for (int j = 0; j < cnt; j++) begin
            act_arr[n_arr] = a;
            case (tbm)
                0:       tb_arr[n_arr] = 1'b1;
                1:       tb_arr[n_arr] = (n_arr % 4 == 0);
                default: tb_arr[n_arr] = 1'($urandom_range(0, 1));
            endcase
            rdy_arr[n_arr] = rdy;
            n_arr++;
        end
    endtask

    function automatic int tsum(input int a, input int b);
        int s = 0;
        for (int k = a; k < b; k++) s += int'(tb_arr[k]);
        return s;
    endfunction

    // Each pair of consecutive active edges with an inactive edge between yields one result.
    task automatic build_expect();
        int ra = -1;
        int fa = -1;
        res_t r;
        for (int i = 1; i < n_arr; i++) begin
            if (act_arr[i] && !act_arr[i-1]) begin
                if (ra >= 0 && fa > ra) begin
                    r.per = tsum(ra + LAT, i + LAT);
                    r.hi  = tsum(ra + LAT, fa + LAT);
                    exp_q.push_back(r);
                end
                ra = i;
            end else if (!act_arr[i] && act_arr[i-1]) begin
                fa = i;
            end
        end
    endtask

    task automatic play(input string tag, input int exp_n);
        pres_cnt = 0;
        for (int i = 0; i < n_arr; i++) cyc(act_arr[i], tb_arr[i], rdy_arr[i]);
        chk({tag, "_results"}, 32'(pres_cnt), 32'(exp_n));
    endtask

    task automatic rearm(input logic pol);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        polarity = pol;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    endtask

    task automatic run_regular(input string tag, input int h, input int l, input int ncyc,
                               input int tbm, input logic pol, input bit rnd);
        int n;
        rearm(pol);
        exp_q.delete();
        n_arr = 0;
        push(1'b0, 6, tbm, 1'b1);
        for (int c = 0; c < ncyc; c++) begin
            push(1'b1, rnd ? int'($urandom_range(3, 90)) : h, tbm, 1'b1);
            push(1'b0, rnd ? int'($urandom_range(3, 90)) : l, tbm, 1'b1);
        end
        push(1'b1, 10, tbm, 1'b1);
        push(1'b0, 10, tbm, 1'b1);
        build_expect();
        n = exp_q.size();
        play(tag, n);
    endtask

    initial begin
        int r1p, r1h, n;
        reset = 1'b1; enable = 1'b0; polarity = 1'b0;
        timebase = 1'b0; pwm_in = 1'b0; data_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("rst_period", 32'(period_out), 0);
        chk("rst_high", 32'(high_time_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_missed", 32'(missed_sample), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;

        run_regular("full_rate", 30, 70, 4, 0, 1'b0, 1'b0);
        run_regular("prescaled", 30, 70, 4, 1, 1'b0, 1'b0);
        run_regular("inverted", 30, 70, 3, 0, 1'b1, 1'b0);
        run_regular("random", 0, 0, 6, 2, 1'b0, 1'b1);

        // Back-pressure: two results while the consumer stalls.
        rearm(1'b0);
        exp_q.delete();
        n_arr = 0;
        push(1'b0, 6, 0, 1'b0);
        push(1'b1, 20, 0, 1'b0); push(1'b0, 30, 0, 1'b0);
        push(1'b1, 20, 0, 1'b0); push(1'b0, 30, 0, 1'b0);
        push(1'b1, 20, 0, 1'b0); push(1'b0, 10, 0, 1'b0);
        build_expect();
        r1p = exp_q[0].per;
        r1h = exp_q[0].hi;
        miss_cnt = 0;
        play("stall", 1);
        chk("stall_missed", 32'(miss_cnt), 1);
        chk("stall_valid", 32'(data_valid), 1);
        chk("stall_hold_per", 32'(period_out), 32'(r1p));
        chk("stall_hold_hi", 32'(high_time_out), 32'(r1h));
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("drain_valid", 32'(data_valid), 0);
        chk("drain_hold_per", 32'(period_out), 32'(r1p));
        exp_q.delete();

        // Constant active level after one edge: saturation, no result.
        rearm(1'b0);
        n_arr = 0;
        push(1'b0, 6, 0, 1'b1);
        push(1'b1, 200, 0, 1'b1);
        play("ovf_a", 0);
        chk("ovf_early", 32'(overflow), 0);
        n_arr = 0;
        push(1'b1, 100, 0, 1'b1);
        play("ovf_b", 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_no_valid", 32'(data_valid), 0);
        rearm(1'b0);
        chk("ovf_cleared", 32'(overflow), 0);
        run_regular("after_ovf", 40, 60, 2, 0, 1'b0, 1'b0);

        // Reset while measuring with a result pending.
        rearm(1'b0);
        exp_q.delete();
        n_arr = 0;
        push(1'b0, 6, 0, 1'b0);
        push(1'b1, 20, 0, 1'b0); push(1'b0, 40, 0, 1'b0);
        push(1'b1, 20, 0, 1'b0); push(1'b0, 40, 0, 1'b0);
        build_expect();
        play("pre_reset", 1);
        chk("pre_reset_valid", 32'(data_valid), 1);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_period", 32'(period_out), 0);
        chk("mid_rst_high", 32'(high_time_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        exp_q.delete();
        n_arr = 0;
        push(1'b0, 6, 2, 1'b1);
        push(1'b1, 25, 2, 1'b1); push(1'b0, 50, 2, 1'b1);
        push(1'b1, 25, 2, 1'b1); push(1'b0, 50, 2, 1'b1);
        push(1'b1, 10, 2, 1'b1); push(1'b0, 10, 2, 1'b1);
        build_expect();
        n = exp_q.size();
        play("post_reset", n);
        chk("post_reset_n", 32'(n), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
